// File: rtl/nibble_serial_adder_pkg.sv
// adder_pkg: FSM state encoding and nibble width shared by the serial adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/nibble_serial_adder_carry_select_adder.sv
// carry_select_adder: 4-bit adder, low pair ripples while the high pair is precomputed for both carries
module carry_select_adder
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [2:0] w_lo;
  logic [2:0] w_hi0;
  logic [2:0] w_hi1;
  assign w_lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b0, cin};
  assign w_hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
  assign w_hi1 = w_hi0 + 3'd1;
  assign sum   = {w_lo[2] ? w_hi1[1:0] : w_hi0[1:0], w_lo[1:0]};
  assign cout  = w_lo[2] ? w_hi1[2] : w_hi0[2];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add performed one nibble per cycle through a single 4-bit slice
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = $clog2(NIB) + 1;
  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_carry;
  logic [CW-1:0]        r_cnt;
  logic [NIBBLE_W-1:0]  w_s;
  logic                 w_co;
  carry_select_adder u_csa (
    .a   (r_a[NIBBLE_W-1:0]),
    .b   (r_b[NIBBLE_W-1:0]),
    .cin (r_carry),
    .sum (w_s),
    .cout(w_co)
  );
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next-state: accept in IDLE, leave RUN after the last nibble, leave DONE on handshake
  always_comb
    w_next = r_state == IDLE ? (in_valid ? RUN : IDLE) :
             r_state == RUN  ? (r_cnt == CW'(NIB - 1) ? DONE : RUN) :
             r_state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  // outputs decoded from registered state; only rst reaches in_ready combinationally
  always_comb begin
    in_ready  = r_state == IDLE && !rst;
    out_valid = r_state == DONE;
    sum       = r_sum;
    cout      = r_carry;
  end
  // datapath: capture operands on accept, then shift one nibble per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= WIDTH'({w_s, r_sum} >> NIBBLE_W);
      r_carry <= w_co;
      r_a     <= r_a >> NIBBLE_W;
      r_b     <= r_b >> NIBBLE_W;
      r_cnt   <= r_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed tests of the 16-bit serial adder
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  int          passed = 0;
  int          total = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if ({cout, sum} !== 17'h0) $display("FAIL reset_sum got %h/%b want 0000/0", sum, cout); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_basic();
    int n;
    accept(16'hABCD, 16'h1234, 1'b0);
    wait_valid(n);
    total++; if (n !== 4) $display("FAIL basic_latency got %0d want 4", n); else passed++;
    total++; if (sum !== 16'hBE01 || cout !== 1'b0) $display("FAIL basic_sum got %h/%b want BE01/0", sum, cout); else passed++;
    handshake();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_return got ov=%b ir=%b want 0/1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_ripple();
    int n;
    accept(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(n);
    total++; if (n !== 4 || sum !== 16'h0000 || cout !== 1'b1) $display("FAIL ripple_ffff got n=%0d %h/%b want 4 0000/1", n, sum, cout); else passed++;
    handshake();
    accept(16'h0000, 16'h0000, 1'b1);
    wait_valid(n);
    total++; if (n !== 4 || sum !== 16'h0001 || cout !== 1'b0) $display("FAIL ripple_cin got n=%0d %h/%b want 4 0001/0", n, sum, cout); else passed++;
    handshake();
  endtask

  task automatic test_backpressure();
    int n;
    accept(16'h1111, 16'h2222, 1'b1);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || sum !== 16'h3334 || cout !== 1'b0)
        $display("FAIL backpressure_hold_%0d got ov=%b %h/%b want 1 3334/0", i, out_valid, sum, cout);
      else passed++;
      step();
    end
    handshake();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL backpressure_release got ov=%b ir=%b want 0/1", out_valid, in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL backpressure_single got ov=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_busy();
    int n;
    int seen = 0;
    accept(16'h0F0F, 16'h00F1, 1'b0);
    a = 16'hFFFF;
    b = 16'hFFFF;
    in_valid = 1'b1;
    total++; if (in_ready !== 1'b0) $display("FAIL busy_in_ready got %b want 0", in_ready); else passed++;
    step();
    in_valid = 1'b0;
    wait_valid(n);
    total++; if (sum !== 16'h1000 || cout !== 1'b0) $display("FAIL busy_sum got %h/%b want 1000/0", sum, cout); else passed++;
    handshake();
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      step();
    end
    total++; if (seen !== 0) $display("FAIL busy_no_capture got %0d extra results want 0", seen); else passed++;
  endtask

  task automatic test_mid_reset();
    int n;
    int seen = 0;
    accept(16'h1234, 16'h1111, 1'b0);
    step();
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got %b want 0", in_ready); else passed++;
    step();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst_outputs got ov=%b %h/%b ir=%b want 0 0000/0 1", out_valid, sum, cout, in_ready); else passed++;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      step();
    end
    total++; if (seen !== 0) $display("FAIL midrst_aborted got %0d results want 0", seen); else passed++;
    accept(16'h8000, 16'h8000, 1'b1);
    wait_valid(n);
    total++; if (n !== 4 || sum !== 16'h0001 || cout !== 1'b1) $display("FAIL midrst_next got n=%0d %h/%b want 4 0001/1", n, sum, cout); else passed++;
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [15:0] opa [3] = '{16'h0001, 16'hFFFF, 16'h7FFF};
    logic [15:0] opb [3] = '{16'h0002, 16'hFFFF, 16'h0001};
    logic        opc [3] = '{1'b0, 1'b1, 1'b0};
    logic [16:0] exp [3] = '{17'h00003, 17'h1FFFF, 17'h08000};
    int acc [3];
    int k = 0;
    int r = 0;
    int cyc = 0;
    logic accepting;
    out_ready = 1'b1;
    a = opa[0]; b = opb[0]; cin = opc[0];
    in_valid = 1'b1;
    while (r < 3 && cyc < 60) begin
      accepting = in_ready && in_valid;
      step();
      cyc++;
      if (accepting) begin
        acc[k] = cyc;
        k++;
        if (k < 3) begin
          a = opa[k]; b = opb[k]; cin = opc[k];
        end else in_valid = 1'b0;
      end
      if (out_valid) begin
        total++;
        if ({cout, sum} !== exp[r]) $display("FAIL b2b_result_%0d got %h/%b want %h", r, sum, cout, exp[r]);
        else passed++;
        r++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (r !== 3 || k !== 3) $display("FAIL b2b_count got results=%0d accepts=%0d want 3/3", r, k); else passed++;
    total++; if (k === 3 && (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6))
      $display("FAIL b2b_interval got %0d,%0d want 6,6", acc[1] - acc[0], acc[2] - acc[1]); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_backpressure();
    test_busy();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
